// File: rtl/obf_key_pkg.sv
// Shared definitions for the c432 key loader: FSM state encoding, key width and counter width.
// Parity support in the loader is selected by the KEY_PARITY_EN macro.
package obf_key_pkg;

    localparam int KEY_W_DEF = 12;
    localparam int CNT_W     = $clog2(KEY_W_DEF + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PAR    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // Even-parity trailer value for a full key.
    function automatic logic even_par(input logic [KEY_W_DEF-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Shadow shift register and beat counter for the serial key; the first bit shifted in ends at bit 0.
// o_shadow_nxt shows the value the register takes at the next edge, so a commit can use the final beat.
module obf_key_shreg
    import obf_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [KEY_W-1:0] o_shadow_nxt,
    output logic             o_full
);

    logic [KEY_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_count;

    // Next shadow value: clear has priority over a shift.
    always_comb begin
        o_shadow_nxt = r_shadow;
        if (i_clear) begin
            o_shadow_nxt = '0;
        end else if (i_shift) begin
            o_shadow_nxt = {i_bit, r_shadow[KEY_W-1:1]};
        end else begin
            o_shadow_nxt = r_shadow;
        end
    end

    // Strobes on the beat that completes the key.
    assign o_full = i_shift & ~i_clear & (r_count == CNT_W'(KEY_W - 1));

    // Shadow and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else begin
            r_shadow <= o_shadow_nxt;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_shift) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obf_key_loader.sv
// Serial key-load controller driving the camouflaged c432 select inputs (key_o[n] -> s_n).
// Define KEY_PARITY_EN to expect an even-parity trailer beat and enable the sticky err_o flag.
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter int KEY_W         = KEY_W_DEF,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             key_bit_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    output logic [KEY_W-1:0] key_o,
    output logic             key_ok_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_ready;
    logic             r_busy;
    logic             r_key_ok;
    logic [KEY_W-1:0] r_key;
    logic [7:0]       r_timer;
    logic             w_start_ok;
    logic             w_beat;
    logic             w_shift;
    logic             w_full;
    logic             w_commit;
    logic [KEY_W-1:0] w_shadow_nxt;
`ifdef KEY_PARITY_EN
    logic             r_err;
    logic             r_from_locked;
    logic             w_err_set;
`endif

    // Start is ignored while settling so a committed key always completes its window.
    assign w_start_ok = start_i & (r_state != ST_SETTLE);
    assign w_beat     = key_valid_i & r_ready;
    assign w_shift    = w_beat & ~start_i & (r_state == ST_SHIFT);

    obf_key_shreg #(.KEY_W(KEY_W)) u_shreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start_ok),
        .i_shift      (w_shift),
        .i_bit        (key_bit_i),
        .o_shadow_nxt (w_shadow_nxt),
        .o_full       (w_full)
    );

    // Next-state and commit decode.
    always_comb begin
        w_nxt    = r_state;
        w_commit = 1'b0;
`ifdef KEY_PARITY_EN
        w_err_set = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_LOCKED: begin
                if (start_i) begin
                    w_nxt = ST_SHIFT;
                end else begin
                    w_nxt = r_state;
                end
            end
            ST_SHIFT: begin
                if (start_i) begin
                    w_nxt = ST_SHIFT;
                end else if (w_full) begin
`ifdef KEY_PARITY_EN
                    w_nxt = ST_PAR;
`else
                    w_nxt    = ST_SETTLE;
                    w_commit = 1'b1;
`endif
                end else begin
                    w_nxt = ST_SHIFT;
                end
            end
            ST_PAR: begin
`ifdef KEY_PARITY_EN
                if (start_i) begin
                    w_nxt = ST_SHIFT;
                end else if (w_beat) begin
                    if (key_bit_i == even_par(w_shadow_nxt)) begin
                        w_nxt    = ST_SETTLE;
                        w_commit = 1'b1;
                    end else begin
                        w_nxt     = r_from_locked ? ST_LOCKED : ST_IDLE;
                        w_err_set = 1'b1;
                    end
                end else begin
                    w_nxt = ST_PAR;
                end
`else
                w_nxt = ST_IDLE;
`endif
            end
            ST_SETTLE: begin
                if (r_timer == 8'd0) begin
                    w_nxt = ST_LOCKED;
                end else begin
                    w_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, settle timer and registered outputs; key_o only moves on a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_key_ok <= 1'b0;
            r_key    <= '0;
            r_timer  <= 8'd0;
        end else begin
            r_state  <= w_nxt;
            r_ready  <= (w_nxt == ST_SHIFT) || (w_nxt == ST_PAR);
            r_busy   <= (w_nxt == ST_SHIFT) || (w_nxt == ST_PAR) || (w_nxt == ST_SETTLE);
            r_key_ok <= (w_nxt == ST_LOCKED);
            if (w_commit) begin
                r_key <= w_shadow_nxt;
            end
            if (w_commit) begin
                r_timer <= SETTLE_INIT;
            end else if ((r_state == ST_SETTLE) && (r_timer != 8'd0)) begin
                r_timer <= r_timer - 8'd1;
            end
        end
    end

`ifdef KEY_PARITY_EN
    // Sticky parity error and the state to fall back to on a bad trailer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err         <= 1'b0;
            r_from_locked <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_start_ok && (r_state == ST_LOCKED)) begin
                r_from_locked <= 1'b1;
            end else if (w_start_ok && (r_state == ST_IDLE)) begin
                r_from_locked <= 1'b0;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign key_ready_o = r_ready;
    assign key_o       = r_key;
    assign key_ok_o    = r_key_ok;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_obf_key_loader.sv
// Scoreboard bench for obf_key_loader: the driver queues expected key/ok/err events with their
// arrival cycle, and a negedge monitor pops and compares them as the outputs change.
module tb_obf_key_loader;

    localparam int KEY_W  = 12;
    localparam int SETTLE = 4;
    localparam int EV_KEY = 0;
    localparam int EV_OK  = 1;
    localparam int EV_ERR = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             key_bit_i = 1'b0;
    logic             key_valid_i = 1'b0;
    logic             key_ready_o;
    logic [KEY_W-1:0] key_o;
    logic             key_ok_o;
    logic             busy_o;
    logic             err_o;

    typedef struct {
        int               kind;
        logic [KEY_W-1:0] val;
        int               at;
    } exp_t;

    exp_t             sb_q[$];
    int               n_tests = 0;
    int               n_fail = 0;
    int               neg_cnt = 0;
    logic [KEY_W-1:0] cur_key = 12'h000;
    bit               locked = 1'b0;

    obf_key_loader #(.KEY_W(KEY_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .key_bit_i   (key_bit_i),
        .key_valid_i (key_valid_i),
        .key_ready_o (key_ready_o),
        .key_o       (key_o),
        .key_ok_o    (key_ok_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input int kind, input logic [KEY_W-1:0] val);
        exp_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: event kind %0d val %0h at %0d, expected no event", kind, val, neg_cnt);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.val !== val || e.at != neg_cnt) begin
                n_fail++;
                $display("FAIL sb_event: got kind %0d val %0h at %0d, expected kind %0d val %0h at %0d",
                         kind, val, neg_cnt, e.kind, e.val, e.at);
            end
        end
    endtask

    initial begin : monitor
        logic [KEY_W-1:0] prev_key;
        logic             prev_ok;
        logic             prev_err;
        prev_key = 12'h000;
        prev_ok  = 1'b0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (rst_n) begin
                if (key_o !== prev_key) sb_check(EV_KEY, key_o);
                if (key_ok_o && !prev_ok) sb_check(EV_OK, 12'h000);
                if (err_o && !prev_err) sb_check(EV_ERR, 12'h000);
            end
            prev_key = key_o;
            prev_ok  = key_ok_o;
            prev_err = err_o;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [KEY_W-1:0] v, input int at);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    // Start pulse carries a valid '1' bit that must never be accepted.
    task automatic start_pulse();
        key_valid_i = 1'b1;
        key_bit_i   = 1'b1;
        start_i     = 1'b1;
        cyc();
        start_i     = 1'b0;
        key_valid_i = 1'b0;
    endtask

    task automatic partial(input int n);
        start_pulse();
        for (int i = 0; i < n; i++) begin
            key_valid_i = 1'b1;
            key_bit_i   = 1'b1;
            cyc();
        end
        key_valid_i = 1'b0;
        check("partial_busy", busy_o, 1);
    endtask

    task automatic load(input logic [KEY_W-1:0] k, input bit toggle, input bit bad);
        start_pulse();
        check("start_err_clr", err_o, 0);
        check("start_ready", key_ready_o, 1);
        check("start_busy", busy_o, 1);
        check("start_ok_low", key_ok_o, 0);
        for (int i = 0; i < KEY_W; i++) begin
            if (toggle) begin
                key_valid_i = 1'b0;
                cyc();
                check("bp_ready", key_ready_o, 1);
            end
            key_valid_i = 1'b1;
            key_bit_i   = k[i];
            cyc();
            if (i == 6) begin
                check("hold_old_key", key_o, cur_key);
                check("ok_low_loading", key_ok_o, 0);
            end
        end
`ifdef KEY_PARITY_EN
        key_bit_i = (^k) ^ bad;
        cyc();
`endif
        key_valid_i = 1'b0;
        if (bad) begin
            if (locked) push(EV_OK, 12'h000, neg_cnt + 1);
            push(EV_ERR, 12'h000, neg_cnt + 1);
        end else begin
            push(EV_KEY, k, neg_cnt + 1);
            push(EV_OK, 12'h000, neg_cnt + 1 + SETTLE);
            cur_key = k;
            locked  = 1'b1;
            for (int i = 0; i < 40 && !key_ok_o; i++) cyc();
            check("ok_settled", key_ok_o, 1);
            check("key_final", key_o, k);
            check("locked_busy", busy_o, 0);
            check("locked_ready", key_ready_o, 0);
        end
    endtask

    initial begin
        // T1: reset values, reset mid-load, then a clean load
        repeat (3) cyc();
        check("rst_key", key_o, 0);
        check("rst_ok", key_ok_o, 0);
        check("rst_ready", key_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1;
        cyc();
        partial(5);
        rst_n = 1'b0;
        #2;
        check("midrst_key", key_o, 0);
        check("midrst_ok", key_ok_o, 0);
        check("midrst_ready", key_ready_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_err", err_o, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        load(12'h001, 1'b0, 1'b0);

        // T2: plain load, then valid without start in LOCKED is ignored
        load(12'hA5C, 1'b0, 1'b0);
        key_valid_i = 1'b1;
        key_bit_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("locked_ign_ready", key_ready_o, 0);
            check("locked_ign_ok", key_ok_o, 1);
        end
        key_valid_i = 1'b0;
        cyc();

        // T4: reload keeps old key until commit
        load(12'h3F0, 1'b0, 1'b0);

        // T3: backpressure
        load(12'hA5C, 1'b1, 1'b0);

        // T5: restart after 7 beats
        partial(7);
        load(12'h001, 1'b0, 1'b0);

`ifdef KEY_PARITY_EN
        // T6: bad parity trailer from LOCKED, then a good load clears err_o
        load(12'hA5C, 1'b0, 1'b1);
        cyc();
        check("par_err", err_o, 1);
        check("par_key_kept", key_o, 12'h001);
        check("par_busy", busy_o, 0);
        check("par_back_locked", key_ok_o, 1);
        load(12'h3F0, 1'b0, 1'b0);
        check("par_err_cleared", err_o, 0);
`endif

        repeat (3) cyc();
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
